// File: rtl/signal_sequencer_if.sv
// signal_sequencer_if: green-time inputs, enable and lamp/status outputs of the phase sequencer
interface signal_sequencer_if;
  logic       enable;
  logic [7:0] TGn, TGe, TGs, TGw;
  logic [1:0] next_road, active_road;
  logic [1:0] light_n, light_e, light_s, light_w;
  logic [7:0] sec_remaining;
  logic       green_done;
  modport master (
    output enable, TGn, TGe, TGs, TGw,
    input  next_road, active_road, light_n, light_e, light_s, light_w, sec_remaining, green_done
  );
  modport slave (
    input  enable, TGn, TGe, TGs, TGw,
    output next_road, active_road, light_n, light_e, light_s, light_w, sec_remaining, green_done
  );
endinterface

// File: rtl/signal_sequencer.sv
// signal_sequencer: round-robin N/E/S/W GREEN/YELLOW/ALL-RED lamp sequencer.
// Define GREEN_CLAMP_EN to saturate the sampled green time to [T_MIN, T_MAX].
module signal_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_MIN    = 5,
  parameter int T_MAX    = 120
) (
  input logic               clk,
  input logic               reset_n,
  signal_sequencer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} state_t;
  state_t          state;
  logic [PW-1:0]   presc;
  logic [3:0][1:0] lights;
  logic [7:0]      tg, g;
  logic            tick;
  if (TICK_DIV < 2 || T_YELLOW < 1 || T_YELLOW > 255 || T_ALLRED < 1 || T_ALLRED > 255 ||
      T_MIN < 1 || T_MIN > T_MAX || T_MAX > 255) begin : g_param_check
    $error("signal_sequencer: timing parameters out of range");
  end
  assign tick = bus.enable && presc == P_LAST;
  assign {bus.light_w, bus.light_s, bus.light_e, bus.light_n} = lights;
  always_comb begin
    tg = bus.next_road == 2'd0 ? bus.TGn :
         bus.next_road == 2'd1 ? bus.TGe :
         bus.next_road == 2'd2 ? bus.TGs : bus.TGw;
`ifdef GREEN_CLAMP_EN
    g = tg < 8'(T_MIN) ? 8'(T_MIN) : tg > 8'(T_MAX) ? 8'(T_MAX) : tg;
`else
    g = tg == 8'd0 ? 8'd1 : tg;
`endif
  end
  // Transitions only happen on a tick, where the prescaler wraps to 0 anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ALLRED;
      presc             <= '0;
      lights            <= '0;
      bus.next_road     <= 2'd0;
      bus.active_road   <= 2'd3;
      bus.sec_remaining <= 8'(T_ALLRED);
      bus.green_done    <= 1'b0;
    end else begin
      bus.green_done <= 1'b0;
      if (bus.enable) presc <= tick ? '0 : presc + 1'b1;
      if (tick && bus.sec_remaining != 8'd1) bus.sec_remaining <= bus.sec_remaining - 8'd1;
      else if (tick) begin
        case (state)
          ALLRED: begin
            state                 <= GREEN;
            bus.active_road       <= bus.next_road;
            lights[bus.next_road] <= 2'b01;
            bus.sec_remaining     <= g;
          end
          GREEN: begin
            state                   <= YELLOW;
            lights[bus.active_road] <= 2'b10;
            bus.sec_remaining       <= 8'(T_YELLOW);
            bus.green_done          <= 1'b1;
            bus.next_road           <= bus.active_road + 2'd1;
          end
          default: begin
            state             <= ALLRED;
            lights            <= '0;
            bus.sec_remaining <= 8'(T_ALLRED);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_signal_sequencer.sv
// tb_signal_sequencer: directed stimulus, cycle-level phase model and green-length scoreboard
module tb_signal_sequencer;
  localparam int TD = 4, TY = 2, TA = 1, TMIN = 5, TMAX = 120;
`ifdef GREEN_CLAMP_EN
  localparam int N3_LEN = 20, E4_LEN = 20, E2_LEN = 20, S0_LEN = 20, S200_LEN = 480, ROT_LEN = 132;
`else
  localparam int N3_LEN = 12, E4_LEN = 16, E2_LEN = 8, S0_LEN = 4, S200_LEN = 800, ROT_LEN = 120;
`endif
  logic clk, reset_n;
  int n_cmp = 0, n_fail = 0;
  signal_sequencer_if bus();
  signal_sequencer #(.TICK_DIV(TD), .T_YELLOW(TY), .T_ALLRED(TA), .T_MIN(TMIN), .T_MAX(TMAX))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] light_of(input int r);
    return r == 0 ? bus.light_n : r == 1 ? bus.light_e : r == 2 ? bus.light_s : bus.light_w;
  endfunction
  function automatic int tg_of(input int r);
    return r == 0 ? int'(bus.TGn) : r == 1 ? int'(bus.TGe) : r == 2 ? int'(bus.TGs) : int'(bus.TGw);
  endfunction
  function automatic int gval(input int tg);
`ifdef GREEN_CLAMP_EN
    return tg < TMIN ? TMIN : tg > TMAX ? TMAX : tg;
`else
    return tg == 0 ? 1 : tg;
`endif
  endfunction
  // Model: phase, serving road and enabled cycles elapsed against the phase length in seconds.
  int m_phase = 0, m_road = 3, m_next = 0, m_el = 0, m_len = TA, m_gd = 0;
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      m_phase = 0; m_road = 3; m_next = 0; m_el = 0; m_len = TA; m_gd = 0;
    end else begin
      m_gd = 0;
      if (bus.enable) begin
        m_el++;
        if (m_el == m_len * TD) begin
          m_el = 0;
          if (m_phase == 0) begin
            m_phase = 1; m_road = m_next; m_len = gval(tg_of(m_next));
          end else if (m_phase == 1) begin
            m_phase = 2; m_len = TY; m_gd = 1; m_next = (m_road + 1) % 4;
          end else begin
            m_phase = 0; m_len = TA;
          end
        end
      end
    end
    for (int r = 0; r < 4; r++)
      check($sformatf("light[%0d]", r), light_of(r),
            r != m_road ? 0 : m_phase == 1 ? 1 : m_phase == 2 ? 2 : 0);
    check("next_road", bus.next_road, m_next);
    check("active_road", bus.active_road, m_road);
    check("sec_remaining", bus.sec_remaining, m_len - m_el / TD);
    check("green_done", bus.green_done, m_gd);
  end
  // Green-length recorder: samples per green interval, in order.
  int q_road[$], q_len[$];
  int cur = 0, cur_r = -1;
  always begin
    int gr;
    @(posedge clk);
    #1;
    gr = -1;
    for (int r = 0; r < 4; r++) if (light_of(r) == 2'b01) gr = r;
    if (gr >= 0) begin
      if (gr == cur_r && cur > 0) cur++;
      else begin
        if (cur > 0) begin q_road.push_back(cur_r); q_len.push_back(cur); end
        cur_r = gr; cur = 1;
      end
    end else if (cur > 0) begin
      q_road.push_back(cur_r); q_len.push_back(cur); cur = 0;
    end
  end
  task automatic wait_light(input int road, input logic [1:0] val, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (light_of(road) == val) return;
    end
    check($sformatf("wait_light_timeout[%0d]", road), 0, 1);
  endtask
  task automatic expect_green(input int road, input int len);
    for (int i = 0; i < 3000 && q_len.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q_len.size() == 0) check("green_timeout", 0, 1);
    else begin
      check("green_road", q_road.pop_front(), road);
      check($sformatf("green_len[%0d]", road), q_len.pop_front(), len);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, n1, n2, n3;
    reset_n = 1'b0;
    bus.enable = 1'b1;
    bus.TGn = 8'd5; bus.TGe = 8'd4; bus.TGs = 8'd5; bus.TGw = 8'd6;
    repeat (3) @(negedge clk);
    check("rst_lights", {bus.light_w, bus.light_s, bus.light_e, bus.light_n}, 0);
    check("rst_next", bus.next_road, 0);
    check("rst_active", bus.active_road, 3);
    check("rst_sec", bus.sec_remaining, 1);
    reset_n = 1'b1;
    wait_light(0, 2'b01, 20, n);
    check("first_green_latency", n, 4);
    wait_light(0, 2'b10, 40, n);
    check("yellow_next_road", bus.next_road, 1);
    check("yellow_green_done", bus.green_done, 1);
    bus.TGn = 8'd3;
    expect_green(0, 20);
    expect_green(1, E4_LEN);
    expect_green(2, 20);
    expect_green(3, 24);
    wait_light(0, 2'b01, 200, n);
    wait_light(0, 2'b10, 200, n1);
    wait_light(1, 2'b01, 200, n2);
    @(negedge clk);
    bus.TGe = 8'd7;
    wait_light(0, 2'b01, 300, n3);
    check("rotation_cycles", n1 + n2 + n3, ROT_LEN);
    expect_green(0, N3_LEN);
    expect_green(1, E4_LEN);
    expect_green(2, 20);
    expect_green(3, 24);
    repeat (3) @(negedge clk);
    bus.TGe = 8'd9;
    bus.TGs = 8'd0;
    wait_light(1, 2'b01, 200, n);
    @(negedge clk);
    bus.TGe = 8'd2;
    wait_light(3, 2'b01, 300, n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sec_remaining == 8'd2) break;
    end
    bus.enable = 1'b0;
    repeat (10) @(negedge clk);
    check("freeze_sec", bus.sec_remaining, 2);
    check("freeze_light_w", bus.light_w, 1);
    bus.enable = 1'b1;
    bus.TGs = 8'd200;
    expect_green(0, N3_LEN);
    expect_green(1, 36);
    expect_green(2, S0_LEN);
    expect_green(3, 34);
    expect_green(0, N3_LEN);
    expect_green(1, E2_LEN);
    expect_green(2, S200_LEN);
    expect_green(3, 24);
    wait_light(3, 2'b10, 50, n);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_lights", {bus.light_w, bus.light_s, bus.light_e, bus.light_n}, 0);
    check("async_rst_next", bus.next_road, 0);
    check("async_rst_active", bus.active_road, 3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_light(0, 2'b01, 20, n);
    check("post_rst_green_latency", n, 4);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/signal_sequencer.md
# signal_sequencer

Four-approach signal phase sequencer downstream of the green-time adaptation stage. It consumes the per-road green times TGn/TGe/TGs/TGw and steps round-robin N→E→S→W through GREEN, YELLOW and ALL-RED phases, driving the lamp outputs. It publishes `next_road` early, at the start of each YELLOW, so the adaptation stage has the whole YELLOW+ALL-RED interval to settle the next road's green time before it is latched.

## Interface
- TICK_DIV, 50_000_000 — clk cycles per one-second tick (≥2)
- T_YELLOW, 3 — yellow duration, seconds (1–255)
- T_ALLRED, 2 — all-red clearance, seconds (1–255)
- T_MIN, 5 — minimum green, seconds (used only with clamp macro)
- T_MAX, 120 — maximum green, seconds (used only with clamp macro)
- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high: timing advances; low: freeze prescaler, countdown and state
- TGn, TGe, TGs, TGw  in  8 each  green time per road, seconds, unsigned
- next_road  out  2  road to be served next (0=N, 1=E, 2=S, 3=W)
- active_road  out  2  road currently or most recently green
- light_n, light_e, light_s, light_w  out  2 each  00 red, 01 green, 10 yellow (11 never driven)
- sec_remaining  out  8  seconds left in current phase, including the current second
- green_done  out  1  one-cycle pulse on the GREEN→YELLOW edge

## Operation
- States: ALLRED, GREEN, YELLOW. All outputs are registered.
- Reset values:
  - state ALLRED; next_road 0; active_road 3; all lights 00.
  - sec_remaining T_ALLRED; green_done 0; prescaler 0.
- Prescaler counts 0..TICK_DIV-1 while enable=1 and issues a tick on the wrap.
  - It clears to 0 on every state transition, so each phase is exactly N×TICK_DIV enabled cycles.
- On a tick with sec_remaining>1: decrement sec_remaining.
- On a tick with sec_remaining==1: transition, and load the new phase duration into sec_remaining.
- ALLRED→GREEN:
  - active_road←next_road.
  - G←TG of next_road, sampled on that edge; sec_remaining←G.
  - Light of active_road←01.
  - A sampled G of 0 is treated as 1.
- GREEN→YELLOW:
  - Light of active_road←10; sec_remaining←T_YELLOW; green_done pulses for one cycle.
  - next_road←active_road+1 mod 4 (wraps 3→0).
- YELLOW→ALLRED: all lights 00; sec_remaining←T_ALLRED.
- Lamps of non-active roads are always 00. At most one road is non-red at any time.
- TG inputs are ignored except on the ALLRED→GREEN edge. Changes during GREEN do not alter the running green.
- enable=0 holds every register, including mid-phase and on a would-be tick cycle. No tick is lost or duplicated when enable returns.
- Reset mid-phase: outputs return to reset values immediately (asynchronous). Sequencing restarts from ALLRED, serving N first.

## Timing
- After reset_n deasserts, the first GREEN (road N) starts T_ALLRED×TICK_DIV enabled cycles later.
- Phase lengths in enabled cycles: GREEN G×TICK_DIV, YELLOW T_YELLOW×TICK_DIV, ALLRED T_ALLRED×TICK_DIV.
- next_road changes on the same edge the lamp goes yellow. The upstream TG for that road must be stable (T_YELLOW+T_ALLRED)×TICK_DIV cycles later.
- Latency from the tick cycle to the new lamp value: one clock edge (registered).

## Configuration
- GREEN_CLAMP_EN defined: sampled G is clamped to [T_MIN, T_MAX] before loading.
  - Out-of-range values are saturated.
  - 0 becomes T_MIN.
- GREEN_CLAMP_EN undefined:
  - G is used as-is, except 0→1.
  - T_MIN and T_MAX are unused.

## Test plan
Bench parameters for all cases: TICK_DIV=4, T_YELLOW=2, T_ALLRED=1, enable=1 unless stated.

- Reset release, TGn=5 → lights all 00 for 4 cycles, then light_n=01 for 20 cycles, 10 for 8 cycles, 00 for 4 cycles. green_done pulses once. next_road=1 from the yellow edge.
- Full rotation, TGn=3, TGe=4, TGs=5, TGw=6 → greens of 12/16/20/24 cycles in order N,E,S,W. next_road wraps 3→0. Total rotation 18×4+4×12=120 cycles.
- TGe changed 7→9 during N's GREEN, stable before ALLRED ends → E green lasts 36 cycles. Changing TGe during E's GREEN has no effect.
- enable held 0 for 10 cycles mid-GREEN with sec_remaining=2 → lamps and sec_remaining frozen. Green still totals exactly G×4 enabled cycles.
- TGs=0, then TGs=200 → without macro: S green of 4 cycles, then 800 cycles. With GREEN_CLAMP_EN (T_MIN=5, T_MAX=120): 20 cycles, then 480 cycles.
- reset_n pulsed low during W YELLOW → all lamps 00 in the same cycle, next_road=0, active_road=3. After release, N is green 4 cycles later.
